// File: rtl/chasebot_param_pkg.sv
// Shared types and constants for the serial parameter loader and the
// per-parameter latches it programs.
package chasebot_param_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_SEL  = 2'd1,
        GET_VAL  = 2'd2,
        GET_CSUM = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_SEL     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         SEL_W             = 3;
    localparam int         VAL_W             = 8;

    // 8-bit wrap-around sum of the three payload-side bytes of a frame.
    function automatic logic [7:0] frame_csum(input logic [7:0] sync_byte,
                                              input logic [7:0] sel_byte,
                                              input logic [7:0] val_byte);
        return sync_byte + sel_byte + val_byte;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter: counts while enabled, clears on demand, and
// flags the final allowed cycle when no clear arrives in it.
module frame_timer #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear || !enable) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 1'b1;
        end
    end

    // A byte arriving in the last cycle clears the timer instead of expiring it.
    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/param_loader.sv
// Validates SYNC/SEL/VALUE/CSUM frames from the UART byte stream and emits a
// one-cycle program_ strobe with the selected parameter and value.
module param_loader
    import chasebot_param_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [SEL_W-1:0] sel_out,
    output logic [VAL_W-1:0] value_out,
    output logic             program_,
    output logic             busy,
    output logic [1:0]       last_err,
    output logic [7:0]       err_count
);

    // rx_valid is a one-cycle qualifier for rx_data with no backpressure:
    // every cycle with rx_valid=1 delivers exactly one byte that must be consumed.

    state_t    state, state_next;
    err_code_t last_err_q;
    err_code_t frame_err;
    logic [7:0] sel_byte, val_byte;
    logic [7:0] expected_csum;
    logic       load_sel, load_val, evaluate, timed_out;
    logic       expired;

    frame_timer #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid),
        .enable (state != IDLE),
        .expired(expired)
    );

    assign expected_csum = frame_csum(SYNC_BYTE, sel_byte, val_byte);

    always_comb begin
        state_next = state;
        load_sel   = 1'b0;
        load_val   = 1'b0;
        evaluate   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_next = GET_SEL;
            end
            GET_SEL: begin
                if (rx_valid) begin
                    load_sel   = 1'b1;
                    state_next = GET_VAL;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            GET_VAL: begin
                if (rx_valid) begin
                    load_val   = 1'b1;
                    state_next = GET_CSUM;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            GET_CSUM: begin
                if (rx_valid) begin
                    evaluate   = 1'b1;
                    state_next = IDLE;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Checksum errors take priority over an out-of-range select.
    always_comb begin
        frame_err = ERR_NONE;
        if (rx_data != expected_csum) begin
            frame_err = ERR_CSUM;
        end else if (sel_byte[7:SEL_W] != '0) begin
            frame_err = ERR_SEL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_byte   <= '0;
            val_byte   <= '0;
            sel_out    <= '0;
            value_out  <= '0;
            program_   <= 1'b0;
            last_err_q <= ERR_NONE;
            err_count  <= '0;
        end else begin
            state    <= state_next;
            program_ <= 1'b0;
            if (load_sel) sel_byte <= rx_data;
            if (load_val) val_byte <= rx_data;
            if (evaluate) begin
                last_err_q <= frame_err;
                if (frame_err == ERR_NONE) begin
                    sel_out   <= sel_byte[SEL_W-1:0];
                    value_out <= val_byte;
                    program_  <= 1'b1;
                end else if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
            if (timed_out) begin
                last_err_q <= ERR_TIMEOUT;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign last_err = last_err_q;

endmodule
